// File: rtl/ysyx_22050710_axil_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_axil_rd_arbiter
// Purpose  : AXI4-Lite 2-master / 1-slave arbiter. The read channels (AR/R)
//            of M0 (instruction fetch, read-only) and M1 (load/store) share
//            the slave with round-robin arbitration and one outstanding read
//            at a time. The M1 write channels (AW/W/B) are wired straight
//            through to the slave with no state.
// Ports    : i_aclk / i_arsetn        clock, synchronous active-low reset
//            i_m0_ar* / o_m0_r*       M0 read address / read data channels
//            i_m1_ar* / o_m1_r*       M1 read address / read data channels
//            i_m1_aw*, i_m1_w*, o_m1_b*  M1 write channels
//            o_s_ar* / i_s_r*         slave read channels
//            o_s_aw*, o_s_w*, i_s_b*  slave write channels
// Revision : 1.0  initial release
// ============================================================================
module ysyx_22050710_axil_rd_arbiter #(
    parameter int ADDR_WD = 64,
    parameter int DATA_WD = 64,
    parameter int STRB_WD = DATA_WD / 8
) (
    input  logic               i_aclk,
    input  logic               i_arsetn,

    // M0 read channels
    input  logic               i_m0_arvalid,
    output logic               o_m0_arready,
    input  logic [ADDR_WD-1:0] i_m0_araddr,
    input  logic [2:0]         i_m0_arprot,
    output logic               o_m0_rvalid,
    input  logic               i_m0_rready,
    output logic [DATA_WD-1:0] o_m0_rdata,
    output logic [1:0]         o_m0_rresp,

    // M1 read channels
    input  logic               i_m1_arvalid,
    output logic               o_m1_arready,
    input  logic [ADDR_WD-1:0] i_m1_araddr,
    input  logic [2:0]         i_m1_arprot,
    output logic               o_m1_rvalid,
    input  logic               i_m1_rready,
    output logic [DATA_WD-1:0] o_m1_rdata,
    output logic [1:0]         o_m1_rresp,

    // M1 write channels
    input  logic               i_m1_awvalid,
    output logic               o_m1_awready,
    input  logic [ADDR_WD-1:0] i_m1_awaddr,
    input  logic [2:0]         i_m1_awprot,
    input  logic               i_m1_wvalid,
    output logic               o_m1_wready,
    input  logic [DATA_WD-1:0] i_m1_wdata,
    input  logic [STRB_WD-1:0] i_m1_wstrb,
    output logic               o_m1_bvalid,
    input  logic               i_m1_bready,
    output logic [1:0]         o_m1_bresp,

    // Slave read channels
    output logic               o_s_arvalid,
    input  logic               i_s_arready,
    output logic [ADDR_WD-1:0] o_s_araddr,
    output logic [2:0]         o_s_arprot,
    input  logic               i_s_rvalid,
    output logic               o_s_rready,
    input  logic [DATA_WD-1:0] i_s_rdata,
    input  logic [1:0]         i_s_rresp,

    // Slave write channels
    output logic               o_s_awvalid,
    input  logic               i_s_awready,
    output logic [ADDR_WD-1:0] o_s_awaddr,
    output logic [2:0]         o_s_awprot,
    output logic               o_s_wvalid,
    input  logic               i_s_wready,
    output logic [DATA_WD-1:0] o_s_wdata,
    output logic [STRB_WD-1:0] o_s_wstrb,
    input  logic               i_s_bvalid,
    output logic               o_s_bready,
    input  logic [1:0]         i_s_bresp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_grant;        // 0 = M0, 1 = M1
    logic   w_grant_nxt;
    logic   r_last_grant;   // master that won the most recent AR handshake
    logic   w_last_grant_nxt;

    logic   w_in_ar;
    logic   w_in_r;
    logic   w_ar_hs;
    logic   w_r_hs;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_aclk) begin
        if (!i_arsetn) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read-channel outputs
    // ------------------------------------------------------------------
    // Qualifying with i_arsetn forces every read-side valid/ready low
    // during the very first reset cycle, before the state register has
    // actually been cleared by the reset edge.
    assign w_in_ar = (r_state == S_AR) && i_arsetn;
    assign w_in_r  = (r_state == S_R)  && i_arsetn;

    // AR channel: the granted master is muxed onto the slave. Address and
    // prot are don't-care outside AR, so they follow the grant mux freely.
    assign o_s_arvalid  = w_in_ar && (r_grant ? i_m1_arvalid : i_m0_arvalid);
    assign o_s_araddr   = r_grant ? i_m1_araddr : i_m0_araddr;
    assign o_s_arprot   = r_grant ? i_m1_arprot : i_m0_arprot;

    // arready depends only on the slave's arready and registered state,
    // never on the same master's arvalid, so no loop is formed.
    assign o_m0_arready = w_in_ar && !r_grant && i_s_arready;
    assign o_m1_arready = w_in_ar &&  r_grant && i_s_arready;

    // R channel: slave data is broadcast; only the granted master sees valid.
    assign o_m0_rvalid  = w_in_r && !r_grant && i_s_rvalid;
    assign o_m1_rvalid  = w_in_r &&  r_grant && i_s_rvalid;
    assign o_m0_rdata   = i_s_rdata;
    assign o_m1_rdata   = i_s_rdata;
    assign o_m0_rresp   = i_s_rresp;
    assign o_m1_rresp   = i_s_rresp;
    assign o_s_rready   = w_in_r && (r_grant ? i_m1_rready : i_m0_rready);

    assign w_ar_hs = o_s_arvalid && i_s_arready;
    assign w_r_hs  = i_s_rvalid && o_s_rready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;

        case (r_state)
            S_IDLE: begin
                if (i_m0_arvalid && i_m1_arvalid) begin
                    // Tie: hand the slave to whoever did not win last time.
                    w_grant_nxt = !r_last_grant;
                    w_state_nxt = S_AR;
                end else if (i_m0_arvalid) begin
                    w_grant_nxt = 1'b0;
                    w_state_nxt = S_AR;
                end else if (i_m1_arvalid) begin
                    w_grant_nxt = 1'b1;
                    w_state_nxt = S_AR;
                end
            end

            S_AR: begin
                if (w_ar_hs) begin
                    w_last_grant_nxt = r_grant;
                    w_state_nxt      = S_R;
                end
            end

            S_R: begin
                if (w_r_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write channels: straight wiring between M1 and the slave
    // ------------------------------------------------------------------
    assign o_s_awvalid  = i_m1_awvalid;
    assign o_m1_awready = i_s_awready;
    assign o_s_awaddr   = i_m1_awaddr;
    assign o_s_awprot   = i_m1_awprot;
    assign o_s_wvalid   = i_m1_wvalid;
    assign o_m1_wready  = i_s_wready;
    assign o_s_wdata    = i_m1_wdata;
    assign o_s_wstrb    = i_m1_wstrb;
    assign o_m1_bvalid  = i_s_bvalid;
    assign o_s_bready   = i_m1_bready;
    assign o_m1_bresp   = i_s_bresp;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050710_axil_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050710_axil_rd_arbiter
// Purpose  : Directed self-checking bench for the AXI4-Lite read arbiter.
//            Inputs change 2 ns after each rising edge; outputs are checked
//            1 ns later, well away from the active edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22050710_axil_rd_arbiter;

    localparam int ADDR_WD = 64;
    localparam int DATA_WD = 64;
    localparam int STRB_WD = DATA_WD / 8;

    logic               clk = 1'b0;
    logic               rstn;
    logic               m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [ADDR_WD-1:0] m0_araddr;
    logic [2:0]         m0_arprot;
    logic [DATA_WD-1:0] m0_rdata;
    logic [1:0]         m0_rresp;
    logic               m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [ADDR_WD-1:0] m1_araddr;
    logic [2:0]         m1_arprot;
    logic [DATA_WD-1:0] m1_rdata;
    logic [1:0]         m1_rresp;
    logic               m1_awvalid, m1_awready, m1_wvalid, m1_wready;
    logic               m1_bvalid, m1_bready;
    logic [ADDR_WD-1:0] m1_awaddr;
    logic [2:0]         m1_awprot;
    logic [DATA_WD-1:0] m1_wdata;
    logic [STRB_WD-1:0] m1_wstrb;
    logic [1:0]         m1_bresp;
    logic               s_arvalid, s_arready, s_rvalid, s_rready;
    logic [ADDR_WD-1:0] s_araddr;
    logic [2:0]         s_arprot;
    logic [DATA_WD-1:0] s_rdata;
    logic [1:0]         s_rresp;
    logic               s_awvalid, s_awready, s_wvalid, s_wready;
    logic               s_bvalid, s_bready;
    logic [ADDR_WD-1:0] s_awaddr;
    logic [2:0]         s_awprot;
    logic [DATA_WD-1:0] s_wdata;
    logic [STRB_WD-1:0] s_wstrb;
    logic [1:0]         s_bresp;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_22050710_axil_rd_arbiter #(
        .ADDR_WD (ADDR_WD),
        .DATA_WD (DATA_WD),
        .STRB_WD (STRB_WD)
    ) dut (
        .i_aclk       (clk),
        .i_arsetn     (rstn),
        .i_m0_arvalid (m0_arvalid),
        .o_m0_arready (m0_arready),
        .i_m0_araddr  (m0_araddr),
        .i_m0_arprot  (m0_arprot),
        .o_m0_rvalid  (m0_rvalid),
        .i_m0_rready  (m0_rready),
        .o_m0_rdata   (m0_rdata),
        .o_m0_rresp   (m0_rresp),
        .i_m1_arvalid (m1_arvalid),
        .o_m1_arready (m1_arready),
        .i_m1_araddr  (m1_araddr),
        .i_m1_arprot  (m1_arprot),
        .o_m1_rvalid  (m1_rvalid),
        .i_m1_rready  (m1_rready),
        .o_m1_rdata   (m1_rdata),
        .o_m1_rresp   (m1_rresp),
        .i_m1_awvalid (m1_awvalid),
        .o_m1_awready (m1_awready),
        .i_m1_awaddr  (m1_awaddr),
        .i_m1_awprot  (m1_awprot),
        .i_m1_wvalid  (m1_wvalid),
        .o_m1_wready  (m1_wready),
        .i_m1_wdata   (m1_wdata),
        .i_m1_wstrb   (m1_wstrb),
        .o_m1_bvalid  (m1_bvalid),
        .i_m1_bready  (m1_bready),
        .o_m1_bresp   (m1_bresp),
        .o_s_arvalid  (s_arvalid),
        .i_s_arready  (s_arready),
        .o_s_araddr   (s_araddr),
        .o_s_arprot   (s_arprot),
        .i_s_rvalid   (s_rvalid),
        .o_s_rready   (s_rready),
        .i_s_rdata    (s_rdata),
        .i_s_rresp    (s_rresp),
        .o_s_awvalid  (s_awvalid),
        .i_s_awready  (s_awready),
        .o_s_awaddr   (s_awaddr),
        .o_s_awprot   (s_awprot),
        .o_s_wvalid   (s_wvalid),
        .i_s_wready   (s_wready),
        .o_s_wdata    (s_wdata),
        .o_s_wstrb    (s_wstrb),
        .i_s_bvalid   (s_bvalid),
        .o_s_bready   (s_bready),
        .i_s_bresp    (s_bresp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // All read-side valid/ready outputs low (IDLE or reset).
    task automatic chk_idle(input string tag);
        #1;
        chk({tag, " s_arvalid"}, 64'(s_arvalid), 64'd0);
        chk({tag, " m0_arready"}, 64'(m0_arready), 64'd0);
        chk({tag, " m1_arready"}, 64'(m1_arready), 64'd0);
        chk({tag, " m0_rvalid"}, 64'(m0_rvalid), 64'd0);
        chk({tag, " m1_rvalid"}, 64'(m1_rvalid), 64'd0);
        chk({tag, " s_rready"}, 64'(s_rready), 64'd0);
    endtask

    // One read starting in an IDLE cycle with requests already raised and
    // slave arready=1: IDLE -> AR (handshake) -> R (handshake) -> IDLE.
    task automatic rd_txn(input string tag, input bit m, input logic [63:0] addr,
                          input logic [63:0] data, input logic [1:0] resp, input bit keep);
        #1;
        chk({tag, " idle s_arvalid"}, 64'(s_arvalid), 64'd0);
        tick(); #1;
        chk({tag, " ar s_arvalid"}, 64'(s_arvalid), 64'd1);
        chk({tag, " ar s_araddr"}, s_araddr, addr);
        chk({tag, " ar m0_arready"}, 64'(m0_arready), 64'(!m));
        chk({tag, " ar m1_arready"}, 64'(m1_arready), 64'(m));
        tick();
        if (!keep) begin
            if (m) m1_arvalid = 1'b0;
            else   m0_arvalid = 1'b0;
        end
        s_rvalid = 1'b1; s_rdata = data; s_rresp = resp;
        #1;
        chk({tag, " r s_arvalid"}, 64'(s_arvalid), 64'd0);
        chk({tag, " r m0_rvalid"}, 64'(m0_rvalid), 64'(!m));
        chk({tag, " r m1_rvalid"}, 64'(m1_rvalid), 64'(m));
        chk({tag, " r rdata"}, m ? m1_rdata : m0_rdata, data);
        chk({tag, " r rresp"}, 64'(m ? m1_rresp : m0_rresp), 64'(resp));
        chk({tag, " r s_rready"}, 64'(s_rready), 64'd1);
        tick();
        s_rvalid = 1'b0;
        #1;
        chk({tag, " done rvalid"}, 64'(m ? m1_rvalid : m0_rvalid), 64'd0);
    endtask

    initial begin
        rstn = 1'b0;
        m0_arvalid = 0; m0_araddr = '0; m0_arprot = 3'd4; m0_rready = 1;
        m1_arvalid = 0; m1_araddr = '0; m1_arprot = 3'd0; m1_rready = 1;
        m1_awvalid = 0; m1_awaddr = '0; m1_awprot = '0; m1_wvalid = 0;
        m1_wdata = '0; m1_wstrb = '0; m1_bready = 0;
        s_arready = 1; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;

        // Reset hold then release with no requests.
        #1;
        chk_idle("rst first cycle");
        tick(); tick(); tick();
        chk_idle("rst held");
        rstn = 1'b1;
        tick(); tick();
        chk_idle("post rst idle");

        // M0 only; arvalid reaches the slave one cycle later.
        m0_arvalid = 1; m0_araddr = 64'h8000_0000;
        #1;
        chk("m0 arprot mux", 64'(s_arprot), 64'd4);
        rd_txn("m0 only", 1'b0, 64'h8000_0000, 64'h13, 2'b00, 1'b0);

        // Fresh reset, then a tie: M1 wins first, then M0.
        rstn = 1'b0; tick(); rstn = 1'b1; tick();
        m0_arvalid = 1; m0_araddr = 64'h8000_0004;
        m1_arvalid = 1; m1_araddr = 64'h8000_1000;
        rd_txn("tie m1", 1'b1, 64'h8000_1000, 64'h1111, 2'b00, 1'b0);
        rd_txn("tie m0", 1'b0, 64'h8000_0004, 64'h2222, 2'b10, 1'b0);

        // Both requesting continuously: M1, M0, M1, M0 with one IDLE gap each.
        m0_arvalid = 1; m1_arvalid = 1;
        rd_txn("rr1 m1", 1'b1, 64'h8000_1000, 64'hA1, 2'b00, 1'b1);
        rd_txn("rr2 m0", 1'b0, 64'h8000_0004, 64'hA2, 2'b00, 1'b1);
        rd_txn("rr3 m1", 1'b1, 64'h8000_1000, 64'hA3, 2'b10, 1'b1);
        rd_txn("rr4 m0", 1'b0, 64'h8000_0004, 64'hA4, 2'b00, 1'b1);
        m0_arvalid = 0; m1_arvalid = 0;

        // Slave stalls AR for 3 cycles, master stalls R for 2 cycles.
        s_arready = 0; m0_arvalid = 1; m0_araddr = 64'h8000_0100;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall ar s_arvalid", 64'(s_arvalid), 64'd1);
            chk("stall ar s_araddr", s_araddr, 64'h8000_0100);
            chk("stall ar m0_arready", 64'(m0_arready), 64'd0);
            tick();
        end
        s_arready = 1;
        #1;
        chk("stall ar release", 64'(m0_arready), 64'd1);
        tick();
        m0_arvalid = 0; m0_rready = 0;
        s_rvalid = 1; s_rdata = 64'h55; s_rresp = 2'b00;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall r m0_rvalid", 64'(m0_rvalid), 64'd1);
            chk("stall r rdata", m0_rdata, 64'h55);
            chk("stall r s_rready", 64'(s_rready), 64'd0);
            tick();
        end
        m0_rready = 1;
        #1;
        chk("stall r release", 64'(s_rready), 64'd1);
        tick();
        s_rvalid = 0;
        chk_idle("stall done");

        // M1 write during an active M0 read.
        m0_arvalid = 1; m0_araddr = 64'h8000_0008;
        tick(); tick();
        m0_arvalid = 0;
        m1_awvalid = 1; m1_awaddr = 64'h8000_2000; m1_awprot = 3'd2;
        m1_wvalid = 1; m1_wdata = 64'hDEAD_BEEF; m1_wstrb = 8'hFF;
        s_awready = 1; s_wready = 1;
        #1;
        chk("wr s_awvalid", 64'(s_awvalid), 64'd1);
        chk("wr s_awaddr", s_awaddr, 64'h8000_2000);
        chk("wr s_awprot", 64'(s_awprot), 64'd2);
        chk("wr s_wvalid", 64'(s_wvalid), 64'd1);
        chk("wr s_wdata", s_wdata, 64'hDEAD_BEEF);
        chk("wr s_wstrb", 64'(s_wstrb), 64'hFF);
        chk("wr m1_awready", 64'(m1_awready), 64'd1);
        chk("wr m1_wready", 64'(m1_wready), 64'd1);
        tick();
        m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0;
        s_bvalid = 1; s_bresp = 2'b00; m1_bready = 1;
        s_rvalid = 1; s_rdata = 64'h1234; s_rresp = 2'b00;
        #1;
        chk("wr m1_bvalid", 64'(m1_bvalid), 64'd1);
        chk("wr s_bready", 64'(s_bready), 64'd1);
        chk("wr m1_bresp", 64'(m1_bresp), 64'd0);
        chk("wr m0 rvalid", 64'(m0_rvalid), 64'd1);
        chk("wr m0 rdata", m0_rdata, 64'h1234);
        chk("wr m1 rvalid", 64'(m1_rvalid), 64'd0);
        tick();
        s_bvalid = 0; m1_bready = 0; s_rvalid = 0;
        chk_idle("wr done");

        // Reset asserted while M1 is in R.
        m1_arvalid = 1; m1_araddr = 64'h8000_3000;
        tick(); tick();
        m1_arvalid = 0;
        s_rvalid = 1; s_rdata = 64'h77;
        m1_rready = 0;
        #1;
        chk("rst-in-r m1_rvalid", 64'(m1_rvalid), 64'd1);
        rstn = 1'b0;
        chk_idle("rst-in-r asserted");
        tick();
        rstn = 1'b1;
        m1_rready = 1;
        chk_idle("rst-in-r after");
        tick();
        chk_idle("rst-in-r stays idle");
        s_rvalid = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22050710_axil_rd_arbiter.md
Name: ysyx_22050710_axil_rd_arbiter

Overview:
- AXI4-Lite 2-master to 1-slave arbiter placed between the CPU's fetch unit (M0, read-only) and load/store unit (M1, read+write), and the shared ysyx_22050710_axil_sram_wrap.
- Read channels use round-robin arbitration, one outstanding read at a time.
- The M1 write channels (AW/W/B) pass straight through to the slave.

Parameters:
- ADDR_WD, 64, AR/AW address width.
- DATA_WD, 64, R/W data width.
- STRB_WD, DATA_WD/8, write strobe width.

Ports:
- i_aclk  in  1  clock.
- i_arsetn  in  1  reset; synchronous, active-low.
- i_m0_arvalid / o_m0_arready  in/out  1  M0 AR handshake.
- i_m0_araddr  in  ADDR_WD  M0 read address.
- i_m0_arprot  in  3  M0 AR protection.
- o_m0_rvalid / i_m0_rready  out/in  1  M0 R handshake.
- o_m0_rdata  out  DATA_WD  M0 read data.
- o_m0_rresp  out  2  M0 read response.
- i_m1_arvalid / o_m1_arready  in/out  1  M1 AR handshake.
- i_m1_araddr  in  ADDR_WD  M1 read address.
- i_m1_arprot  in  3  M1 AR protection.
- o_m1_rvalid / i_m1_rready  out/in  1  M1 R handshake.
- o_m1_rdata  out  DATA_WD  M1 read data.
- o_m1_rresp  out  2  M1 read response.
- i_m1_aw*/w*, o_m1_b*  M1 write channels: awvalid, awaddr[ADDR_WD], awprot[3], wvalid, wdata[DATA_WD], wstrb[STRB_WD], bready in; awready, wready, bvalid, bresp[2] out.
- o_s_arvalid / i_s_arready  out/in  1  slave AR handshake.
- o_s_araddr  out  ADDR_WD  slave read address.
- o_s_arprot  out  3  slave AR protection.
- i_s_rvalid / o_s_rready  in/out  1  slave R handshake.
- i_s_rdata  in  DATA_WD  slave read data.
- i_s_rresp  in  2  slave read response.
- o_s_aw*/w*, i_s_b*  slave write channels, mirror of the M1 write group.

Behaviour:
- Read FSM states: IDLE, AR, R. Registers: state, grant (0=M0, 1=M1), last_grant.
- Reset (i_arsetn=0 at posedge):
  - state=IDLE, grant=0, last_grant=0.
  - All read-side valid/ready outputs are 0 from the first cycle of reset; rdata/rresp/araddr outputs are don't-care.
  - A reset mid-transaction drops the transaction; the slave resets on the same signal.
- IDLE:
  - Arbitration is evaluated on each cycle's inputs.
  - Only one arvalid high: grant that master.
  - Both high: grant !last_grant (round-robin), so the first tie after reset goes to M1.
  - Neither high: stay in IDLE.
  - On a grant, next state is AR; grant is registered.
  - In IDLE, o_s_arvalid=0, both o_mX_arready=0, and both o_mX_rvalid=0.
- AR:
  - o_s_arvalid, o_s_araddr and o_s_arprot mirror the granted master's inputs combinationally.
  - The granted master's o_mX_arready = i_s_arready. The other master's arready is 0.
  - On AR handshake (o_s_arvalid & i_s_arready): last_grant<=grant, next state is R.
- R:
  - o_s_arvalid=0.
  - Granted master: o_mX_rvalid = i_s_rvalid, o_mX_rdata = i_s_rdata, o_mX_rresp = i_s_rresp.
  - o_s_rready = granted master's rready. The other master's rvalid is 0.
  - On R handshake (i_s_rvalid & o_s_rready): next state is IDLE.
- Latency:
  - An arvalid rising in IDLE reaches o_s_arvalid one cycle later.
  - A new grant can be issued in the cycle after the R handshake, i.e. the minimum gap is one IDLE cycle.
- A non-granted master holding arvalid high waits indefinitely; its request is neither dropped nor reordered.
- Handshakes are combinational in the same cycle with no skid buffer. The block must not create combinational loops: arready/rready outputs never depend on the same master's valid.
- Write path:
  - Pure combinational wiring between M1 and the slave; no arbitration and no state.
  - Write and read traffic may overlap; ordering between the two is the LSU's responsibility.
- Any rresp value (including SLVERR=2'b10) is forwarded unmodified.

Test Plan:
- Reset hold then release, no requests -> all o_*valid/o_*ready read outputs remain 0; FSM stays in IDLE.
- M0 only, araddr=0x8000_0000, slave arready on the first AR cycle, rdata=0x0000_0013 after 2 cycles -> o_s_arvalid rises 1 cycle after i_m0_arvalid; o_m0_rdata=0x13, o_m0_rresp=0; o_m1_rvalid stays 0.
- Both arvalid high in the same IDLE cycle right after reset (M0 addr 0x8000_0004, M1 addr 0x8000_1000) -> M1 served first (o_s_araddr=0x8000_1000), then M0 (0x8000_0004).
- Both continuously requesting for 4 reads -> grant order M1, M0, M1, M0; each read is preceded by exactly one IDLE cycle.
- Slave stalls: arready held low 3 cycles, then the granted master holds rready low 2 cycles while rvalid=1 -> araddr/arvalid stable throughout; FSM stays in AR, then R, until the handshakes; rdata stable.
- M1 write to 0x8000_2000, wdata=0xDEAD_BEEF, wstrb=0xFF, issued during an active M0 read -> slave sees AW/W unchanged; B returns to M1; M0 read completes correctly. Separately, reset asserted in R state -> next cycle IDLE with all read valids 0.
